// File: rtl/vout_pkg.sv
// Shared types for the vector-output memory writer: FSM state encoding and
// the skid-buffer entry layout.
package vout_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_REQ,
        S_XFER,
        S_DRAIN,
        S_FIN
    } vout_state_e;

    // Widest memory address the entry can carry; narrower ADDR_W uses the low bits.
    localparam int VOUT_ADDR_MAX = 64;

    typedef struct packed {
        logic [VOUT_ADDR_MAX-1:0] addr;
        logic [31:0]              data;
        logic [3:0]               strb;
    } vout_entry_t;

    localparam int VOUT_ENTRY_W = $bits(vout_entry_t);

endpackage

// File: rtl/vout_skid_buf.sv
// Two-entry skid FIFO between the upstream accept point and the memory write
// port. The head entry is held steady until popped, so downstream outputs stay
// stable while the memory side stalls.
module vout_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o,
    output logic         valid_o,
    output logic         full_o
);

    logic [W-1:0] mem_q [2];
    logic         wr_q;
    logic         rd_q;
    logic [1:0]   cnt_q;

    // Storage, pointers and occupancy; push must only occur when not full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= din_i;
                wr_q        <= ~wr_q;
            end
            if (pop_i) begin
                rd_q <= ~rd_q;
            end
            case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign dout_o  = mem_q[rd_q];
    assign valid_o = (cnt_q != 2'd0);
    assign full_o  = (cnt_q == 2'd2);

endmodule

// File: rtl/vec_out_mem_writer.sv
// Vector-output memory writer: takes rows of packed s8 words from an upstream
// packer and writes them to memory at base + row*stride + word*4.
// Optional build macro VOUT_WR_SKIP_EMPTY_EN: words with an all-zero byte mask
// are accepted but not written (their address slot is simply skipped).
// ADDR_W must not exceed 64.
module vec_out_mem_writer
    import vout_pkg::*;
#(
    parameter int VLEN   = 16,
    parameter int ADDR_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_start,
    input  logic [ADDR_W-1:0]       cfg_base_addr,
    input  logic [ADDR_W-1:0]       cfg_row_stride,
    input  logic [15:0]             cfg_num_rows,
    input  logic [$clog2(VLEN)-1:0] cfg_valid_cols,
    input  logic                    up_req,
    output logic                    up_ack,
    output logic [$clog2(VLEN)-1:0] up_valid_num_col,
    input  logic                    up_valid,
    output logic                    up_ready,
    input  logic [3:0]              up_mask,
    input  logic [31:0]             up_data,
    output logic                    mem_wvalid,
    input  logic                    mem_wready,
    output logic [ADDR_W-1:0]       mem_waddr,
    output logic [31:0]             mem_wdata,
    output logic [3:0]              mem_wstrb,
    output logic                    busy,
    output logic                    done
);

    localparam int CW   = $clog2(VLEN);
    localparam int WPR  = VLEN / 4;
    localparam int WC_W = (WPR > 1) ? $clog2(WPR) : 1;
    localparam logic [WC_W-1:0] LAST_WORD = WC_W'(WPR - 1);

    vout_state_e       state_q;
    logic [ADDR_W-1:0] row_addr_q;
    logic [ADDR_W-1:0] stride_q;
    logic [15:0]       nrows_q;
    logic [CW-1:0]     vcols_q;
    logic [15:0]       row_q;
    logic [WC_W-1:0]   word_q;
    logic              up_ack_q;
    logic              busy_q;
    logic              done_q;

    logic              accept;
    logic              push;
    logic              pop;
    logic              sk_valid;
    logic              sk_full;
    logic [ADDR_W-1:0] word_addr;
    vout_entry_t       ent_in;
    vout_entry_t       sk_head;
    logic              unused_head_addr;

    assign up_ready  = (state_q == S_XFER) && !sk_full;
    assign accept    = up_valid && up_ready;
    // Row base is tracked incrementally, so only the word offset is added here.
    assign word_addr = row_addr_q + (ADDR_W'(word_q) << 2);

`ifdef VOUT_WR_SKIP_EMPTY_EN
    assign push = accept && (up_mask != 4'b0000);
`else
    assign push = accept;
`endif
    assign pop  = sk_valid && mem_wready;

    // Build the entry pushed into the skid buffer for the accepted word.
    always_comb begin
        ent_in                  = '0;
        ent_in.addr[ADDR_W-1:0] = word_addr;
        ent_in.data             = up_data;
        ent_in.strb             = up_mask;
    end

    vout_skid_buf #(
        .W (VOUT_ENTRY_W)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (ent_in),
        .dout_o  (sk_head),
        .valid_o (sk_valid),
        .full_o  (sk_full)
    );

    assign mem_wvalid       = sk_valid;
    assign mem_waddr        = sk_head.addr[ADDR_W-1:0];
    assign mem_wdata        = sk_head.data;
    assign mem_wstrb        = sk_head.strb;
    assign unused_head_addr = ^sk_head.addr;

    assign up_ack           = up_ack_q;
    assign up_valid_num_col = vcols_q;
    assign busy             = busy_q;
    assign done             = done_q;

    // Job sequencing FSM with its counters and registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            row_addr_q <= '0;
            stride_q   <= '0;
            nrows_q    <= '0;
            vcols_q    <= '0;
            row_q      <= '0;
            word_q     <= '0;
            up_ack_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            up_ack_q <= 1'b0;
            done_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cfg_start) begin
                        row_addr_q <= cfg_base_addr;
                        stride_q   <= cfg_row_stride;
                        nrows_q    <= cfg_num_rows;
                        vcols_q    <= cfg_valid_cols;
                        row_q      <= '0;
                        word_q     <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= (cfg_num_rows == 16'd0) ? S_FIN : S_WAIT_REQ;
                    end
                end
                S_WAIT_REQ: begin
                    if (up_req) begin
                        up_ack_q <= 1'b1;
                        state_q  <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (accept) begin
                        if (word_q == LAST_WORD) begin
                            word_q     <= '0;
                            row_q      <= row_q + 16'd1;
                            row_addr_q <= row_addr_q + stride_q;
                            state_q    <= ((row_q + 16'd1) == nrows_q) ? S_DRAIN : S_WAIT_REQ;
                        end else begin
                            word_q <= word_q + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!sk_valid) begin
                        state_q <= S_FIN;
                    end
                end
                S_FIN: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vec_out_mem_writer.sv
// Directed testbench for vec_out_mem_writer (VLEN=16, ADDR_W=32).
module tb_vec_out_mem_writer;

    localparam int VLEN   = 16;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_start;
    logic [ADDR_W-1:0] cfg_base_addr;
    logic [ADDR_W-1:0] cfg_row_stride;
    logic [15:0]       cfg_num_rows;
    logic [3:0]        cfg_valid_cols;
    logic              up_req;
    logic              up_ack;
    logic [3:0]        up_valid_num_col;
    logic              up_valid;
    logic              up_ready;
    logic [3:0]        up_mask;
    logic [31:0]       up_data;
    logic              mem_wvalid;
    logic              mem_wready;
    logic [ADDR_W-1:0] mem_waddr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wstrb;
    logic              busy;
    logic              done;

    always #5 clk = ~clk;

    vec_out_mem_writer #(.VLEN(VLEN), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_base_addr(cfg_base_addr),
        .cfg_row_stride(cfg_row_stride), .cfg_num_rows(cfg_num_rows),
        .cfg_valid_cols(cfg_valid_cols), .up_req(up_req), .up_ack(up_ack),
        .up_valid_num_col(up_valid_num_col), .up_valid(up_valid), .up_ready(up_ready),
        .up_mask(up_mask), .up_data(up_data), .mem_wvalid(mem_wvalid),
        .mem_wready(mem_wready), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .busy(busy), .done(done)
    );

    int checks   = 0;
    int failures = 0;

    logic [31:0] wq_addr [$];
    logic [31:0] wq_data [$];
    logic [3:0]  wq_strb [$];
    int ack_cnt  = 0;
    int done_cnt = 0;
    int acc_cnt  = 0;

    // Record memory writes and handshake events as they complete on the edge.
    always @(posedge clk) begin
        if (!rst) begin
            if (mem_wvalid && mem_wready) begin
                wq_addr.push_back(mem_waddr);
                wq_data.push_back(mem_wdata);
                wq_strb.push_back(mem_wstrb);
            end
            if (up_ack)               ack_cnt  <= ack_cnt + 1;
            if (done)                 done_cnt <= done_cnt + 1;
            if (up_valid && up_ready) acc_cnt  <= acc_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_job(input logic [31:0] base, input logic [31:0] stride,
                             input logic [15:0] rows, input logic [3:0] cols);
        cfg_base_addr  = base;
        cfg_row_stride = stride;
        cfg_num_rows   = rows;
        cfg_valid_cols = cols;
        cfg_start      = 1'b1;
        @(negedge clk);
        cfg_start      = 1'b0;
    endtask

    task automatic get_row();
        int i;
        i = 0;
        up_req = 1'b1;
        do begin
            @(negedge clk);
            i++;
        end while (!up_ack && i < 20);
        up_req = 1'b0;
        chk("ack_seen", up_ack, 1);
    endtask

    task automatic send_word(input logic [31:0] d, input logic [3:0] m, output int waits);
        waits    = 0;
        up_valid = 1'b1;
        up_data  = d;
        up_mask  = m;
        while (!up_ready && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        @(posedge clk);
        @(negedge clk);
        up_valid = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        int i;
        i = 0;
        while (done_cnt == d0 && i < 100) begin
            @(negedge clk);
            i++;
        end
        chk("done_seen", done_cnt - d0, 1);
    endtask

    initial begin
        int a0, d0, w0, a_acc, wt, nexp;
        logic [3:0] exp_strb [4];
        exp_strb = '{4'hF, 4'h3, 4'h0, 4'h0};

        rst = 1'b1; cfg_start = 1'b0; cfg_base_addr = '0; cfg_row_stride = '0;
        cfg_num_rows = '0; cfg_valid_cols = '0; up_req = 1'b0; up_valid = 1'b0;
        up_mask = '0; up_data = '0; mem_wready = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_up_ack", up_ack, 0);
        chk("rst_up_ready", up_ready, 0);
        chk("rst_mem_wvalid", mem_wvalid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_waddr", mem_waddr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_wstrb", mem_wstrb, 0);
        chk("rst_num_col", up_valid_num_col, 0);
        rst = 1'b0;
        @(negedge clk);

        // up_req in IDLE is ignored
        up_req = 1'b1;
        repeat (4) @(negedge clk);
        up_req = 1'b0;
        chk("idle_req_no_ack", ack_cnt, 0);
        chk("idle_busy", busy, 0);

        // Two-row job at full rate; a second start mid-job must be ignored
        a0 = ack_cnt; d0 = done_cnt; w0 = wq_addr.size();
        start_job(32'h1000, 32'h40, 16'd2, 4'd15);
        chk("job_busy", busy, 1);
        for (int r = 0; r < 2; r++) begin
            if (r == 1) begin
                cfg_base_addr = 32'h9000; cfg_num_rows = 16'd5; cfg_start = 1'b1;
                @(negedge clk);
                cfg_start = 1'b0;
            end
            get_row();
            for (int w = 0; w < 4; w++) begin
                send_word(32'hC0DE_0000 | (r << 8) | w, 4'hF, wt);
                chk($sformatf("rate_r%0d_w%0d", r, w), wt, 0);
            end
        end
        wait_done(d0);
        repeat (2) @(negedge clk);
        chk("job_done_once", done_cnt - d0, 1);
        chk("job_busy_after", busy, 0);
        chk("job_acks", ack_cnt - a0, 2);
        chk("job_nwrites", wq_addr.size() - w0, 8);
        for (int r = 0; r < 2; r++) begin
            for (int w = 0; w < 4; w++) begin
                if (w0 + r*4 + w < wq_addr.size()) begin
                    chk($sformatf("job_addr_%0d_%0d", r, w), wq_addr[w0 + r*4 + w], 32'h1000 + r*32'h40 + w*4);
                    chk($sformatf("job_data_%0d_%0d", r, w), wq_data[w0 + r*4 + w], 32'hC0DE_0000 | (r << 8) | w);
                    chk($sformatf("job_strb_%0d_%0d", r, w), wq_strb[w0 + r*4 + w], 4'hF);
                end
            end
        end

        // Partial row: masks copied to strobes
        d0 = done_cnt; w0 = wq_addr.size();
        start_job(32'h5000, 32'h40, 16'd1, 4'd6);
        chk("part_num_col", up_valid_num_col, 6);
        get_row();
        for (int w = 0; w < 4; w++) send_word(32'h1122_3300 | w, exp_strb[w], wt);
        wait_done(d0);
`ifdef VOUT_WR_SKIP_EMPTY_EN
        nexp = 2;
`else
        nexp = 4;
`endif
        chk("part_nwrites", wq_addr.size() - w0, nexp);
        for (int i = 0; i < nexp; i++) begin
            if (w0 + i < wq_addr.size()) begin
                chk($sformatf("part_strb_%0d", i), wq_strb[w0 + i], exp_strb[i]);
                chk($sformatf("part_addr_%0d", i), wq_addr[w0 + i], 32'h5000 + i*4);
            end
        end

        // Zero-row job: done two cycles after start, no ack even with up_req high
        a0 = ack_cnt;
        cfg_num_rows = 16'd0; cfg_start = 1'b1; up_req = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        chk("zero_done_n1", done, 0);
        chk("zero_busy_n1", busy, 1);
        @(negedge clk);
        chk("zero_done_n2", done, 1);
        chk("zero_busy_n2", busy, 0);
        @(negedge clk);
        chk("zero_done_n3", done, 0);
        up_req = 1'b0;
        chk("zero_no_ack", ack_cnt - a0, 0);

        // Memory stall mid-row: two words absorbed, outputs held, then full rate
        mem_wready = 1'b0;
        d0 = done_cnt; w0 = wq_addr.size();
        start_job(32'h2000, 32'h40, 16'd1, 4'd15);
        get_row();
        a_acc = acc_cnt;
        send_word(32'hD000_0000, 4'hF, wt);
        send_word(32'hD000_0001, 4'hF, wt);
        up_valid = 1'b1; up_data = 32'hD000_0002; up_mask = 4'hF;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("stall_ready_%0d", i), up_ready, 0);
            chk($sformatf("stall_wvalid_%0d", i), mem_wvalid, 1);
            chk($sformatf("stall_waddr_%0d", i), mem_waddr, 32'h2000);
            chk($sformatf("stall_wdata_%0d", i), mem_wdata, 32'hD000_0000);
            @(negedge clk);
        end
        chk("stall_accepted", acc_cnt - a_acc, 2);
        mem_wready = 1'b1;
        send_word(32'hD000_0002, 4'hF, wt);
        chk("stall_resume_w2", wt, 1);
        send_word(32'hD000_0003, 4'hF, wt);
        chk("stall_resume_w3", wt, 0);
        wait_done(d0);
        chk("stall_nwrites", wq_addr.size() - w0, 4);
        for (int w = 0; w < 4; w++) begin
            if (w0 + w < wq_addr.size()) begin
                chk($sformatf("stall_addr_%0d", w), wq_addr[w0 + w], 32'h2000 + w*4);
                chk($sformatf("stall_data_%0d", w), wq_data[w0 + w], 32'hD000_0000 | w);
            end
        end

        // Reset mid-job, then a clean restart
        start_job(32'h3000, 32'h40, 16'd2, 4'd15);
        get_row();
        for (int w = 0; w < 3; w++) send_word(32'hE000_0000 | w, 4'hF, wt);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_busy", busy, 0);
        chk("mrst_up_ready", up_ready, 0);
        chk("mrst_up_ack", up_ack, 0);
        chk("mrst_wvalid", mem_wvalid, 0);
        chk("mrst_done", done, 0);
        chk("mrst_waddr", mem_waddr, 0);
        chk("mrst_wdata", mem_wdata, 0);
        chk("mrst_wstrb", mem_wstrb, 0);
        chk("mrst_num_col", up_valid_num_col, 0);
        rst = 1'b0;
        @(negedge clk);
        d0 = done_cnt; w0 = wq_addr.size();
        start_job(32'h4000, 32'h40, 16'd1, 4'd15);
        get_row();
        for (int w = 0; w < 4; w++) send_word(32'hF000_0000 | w, 4'hF, wt);
        wait_done(d0);
        chk("rerun_nwrites", wq_addr.size() - w0, 4);
        for (int w = 0; w < 4; w++) begin
            if (w0 + w < wq_addr.size()) begin
                chk($sformatf("rerun_addr_%0d", w), wq_addr[w0 + w], 32'h4000 + w*4);
                chk($sformatf("rerun_data_%0d", w), wq_data[w0 + w], 32'hF000_0000 | w);
            end
        end
        chk("rerun_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vec_out_mem_writer.md
VEC_OUT_MEM_WRITER -- requirements
Module: vec_out_mem_writer

Interface
REQ-001 Parameter VLEN, default 16: s8 elements per row; multiple of 4, at least 4; words per row WPR = VLEN/4.
REQ-002 Parameter ADDR_W, default 32: memory byte-address width.
REQ-003 Port clk, input, 1: the block's single clock; all logic on its rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous and active-high.
REQ-005 Port cfg_start, input, 1: one-cycle start pulse; sampled only in IDLE.
REQ-006 Port cfg_base_addr, input, ADDR_W: byte address of row 0, word 0; 4-byte aligned.
REQ-007 Port cfg_row_stride, input, ADDR_W: byte distance between consecutive rows; 4-byte aligned.
REQ-008 Port cfg_num_rows, input, 16: number of rows in the job.
REQ-009 Port cfg_valid_cols, input, $clog2(VLEN): valid bytes per row.
REQ-010 Port up_req, input, 1: upstream packer has a row ready.
REQ-011 Port up_ack, output, 1: one-cycle grant of up_req.
REQ-012 Port up_valid_num_col, output, $clog2(VLEN): valid bytes per row; driven from the cfg_valid_cols value latched at start.
REQ-013 Port up_valid, input, 1: upstream word valid.
REQ-014 Port up_ready, output, 1: this block accepts the upstream word.
REQ-015 Port up_mask, input, 4: byte-valid mask; bit i qualifies up_data[8i+7:8i].
REQ-016 Port up_data, input, 32: packed s8 word.
REQ-017 Port mem_wvalid, output, 1: memory write request.
REQ-018 Port mem_wready, input, 1: memory accepts the write.
REQ-019 Port mem_waddr, output, ADDR_W: write byte address.
REQ-020 Port mem_wdata, output, 32: write data.
REQ-021 Port mem_wstrb, output, 4: byte strobes; equal to the word's up_mask.
REQ-022 Port busy, output, 1: high from the start-accept cycle until the cycle done pulses.
REQ-023 Port done, output, 1: one-cycle pulse when the job completes.

Function
REQ-030 States: IDLE, WAIT_REQ, XFER, DRAIN, FIN.
REQ-031 IDLE: on cfg_start, latch all cfg_* inputs, clear the row and word counters, and enter WAIT_REQ; if cfg_num_rows is 0, enter FIN instead.
REQ-032 WAIT_REQ: while up_req is high, assert up_ack for exactly one cycle, then enter XFER.
REQ-033 XFER: up_ready = !skid_full; each up_valid & up_ready handshake is one word; the word counter increments modulo WPR.
REQ-034 Address of each word = base + row*stride + word*4; arithmetic is modulo 2^ADDR_W; no overflow detection.
REQ-035 XFER exit: on accepting word WPR-1, increment the row counter; if rows remain, go to WAIT_REQ, otherwise go to DRAIN.
REQ-036 DRAIN: wait until the skid buffer is empty and no mem_wvalid is pending, then go to FIN.
REQ-037 FIN: pulse done for one cycle, deassert busy in the same cycle, and return to IDLE.
REQ-038 Latency: a word accepted in cycle N is presented on mem_wvalid in cycle N+1 if the buffer is empty.
REQ-039 mem_wvalid, mem_waddr, mem_wdata and mem_wstrb stay stable while mem_wvalid is high and mem_wready is low.
REQ-040 A 2-entry skid buffer holds {addr, data, strb}; with mem_wready held low, at most 2 words are accepted, then up_ready drops.
REQ-041 Accept and issue in the same cycle keep the buffer occupancy unchanged; full throughput is 1 word per cycle.
REQ-042 Ignored inputs:
- cfg_start outside IDLE;
- up_req outside WAIT_REQ;
- up_valid outside XFER (up_ready is 0 there).
REQ-043 up_ack is never asserted for a row beyond cfg_num_rows.

Reset
REQ-050 While rst is high:
- state returns to IDLE;
- counters and skid buffer are cleared;
- up_ack, up_ready, mem_wvalid, busy and done are 0;
- mem_waddr, mem_wdata, mem_wstrb and up_valid_num_col are 0.
REQ-051 Reset mid-job abandons the job; any pending write is dropped without handshake.

Configuration
REQ-060 Macro VOUT_WR_SKIP_EMPTY_EN.
- Defined: a word with up_mask 4'b0000 is accepted but never written to memory; its address slot is skipped.
- Not defined: such a word is written with mem_wstrb 4'b0000.

Structure
REQ-070 Package vout_pkg holds the state enum type and the skid-entry struct {addr, data, strb}.
REQ-071 The 2-entry skid buffer is sub-module vout_skid_buf, parameterised on entry width.

Verification
REQ-080 VLEN=16, base 0x1000, stride 0x40, 2 rows, mem_wready tied high -> 8 writes at 0x1000/04/08/0C/40/44/48/4C; done pulses once; busy is 0 afterwards.
REQ-081 cfg_valid_cols=6, last upstream mask 4'b0011 -> mem_wstrb 1111,0011,0000,0000; with the macro defined, only 2 writes.
REQ-082 mem_wready low for 10 cycles mid-row -> exactly 2 words accepted, up_ready low, outputs stable; full rate resumes on release.
REQ-083 cfg_num_rows=0 -> no up_ack; done pulses 2 cycles after cfg_start.
REQ-084 rst asserted after 3 words of row 0 -> all outputs 0 next cycle; a new cfg_start runs cleanly from row 0.
REQ-085 cfg_start while busy, or up_req in IDLE -> ignored; no up_ack.
